// File: rtl/core_data_req_slice.sv
// Elastic slice in front of the cluster core data demux: a small request FIFO
// cuts the gnt path, responses pass through one register stage.
module core_data_req_slice #(
  parameter  int AddrWidth      = 32,
  parameter  int DataWidth      = 32,
  parameter  int Depth          = 2,
  parameter  int MaxOutstanding = 4,
  localparam int ByteEnable     = DataWidth / 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  core_req_i,
  input  logic [AddrWidth-1:0]                  core_add_i,
  input  logic                                  core_wen_i,
  input  logic [DataWidth-1:0]                  core_wdata_i,
  input  logic [ByteEnable-1:0]                 core_be_i,
  output logic                                  core_gnt_o,
  output logic                                  core_r_valid_o,
  output logic [DataWidth-1:0]                  core_r_rdata_o,
  output logic                                  demux_req_o,
  output logic [AddrWidth-1:0]                  demux_add_o,
  output logic                                  demux_wen_o,
  output logic [DataWidth-1:0]                  demux_wdata_o,
  output logic [ByteEnable-1:0]                 demux_be_o,
  input  logic                                  demux_gnt_i,
  input  logic                                  demux_r_valid_i,
  input  logic [DataWidth-1:0]                  demux_r_rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic [31:0]                           stall_cnt_o
);

  localparam int OutW = $clog2(MaxOutstanding + 1);
  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int EntW = AddrWidth + 1 + DataWidth + ByteEnable;

  localparam logic [OutW-1:0] MaxOut  = OutW'(MaxOutstanding);
  localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  logic [EntW-1:0]      mem_p0 [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [CntW-1:0]      fifo_cnt;
  logic [OutW-1:0]      out_cnt;
  logic [31:0]          stall_cnt;
  logic                 vld_p1;
  logic [DataWidth-1:0] rdata_p1;
  logic                 push;
  logic                 pop;
  logic                 rsp_retire;
  logic [EntW-1:0]      head;

  // Grant looks only at registered occupancy, so a full FIFO blocks even when
  // the head is popped in the same cycle.
  assign core_gnt_o  = core_req_i & (fifo_cnt < DepthC) & (out_cnt < MaxOut);
  assign push        = core_gnt_o;
  assign demux_req_o = (fifo_cnt != '0);
  assign pop         = demux_req_o & demux_gnt_i;
  assign rsp_retire  = vld_p1 & (out_cnt != '0);
  assign head        = demux_req_o ? mem_p0[rd_ptr] : '0;

  assign {demux_add_o, demux_wen_o, demux_wdata_o, demux_be_o} = head;

  assign core_r_valid_o = vld_p1;
  assign core_r_rdata_o = rdata_p1;
  assign outstanding_o  = out_cnt;
  assign stall_cnt_o    = stall_cnt;

  // Stage p0: request FIFO control
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CntW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CntW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_p0[wr_ptr] <= {core_add_i, core_wen_i, core_wdata_i, core_be_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      case ({push, rsp_retire})
        2'b10:   out_cnt <= out_cnt + OutW'(1);
        2'b01:   out_cnt <= out_cnt - OutW'(1);
        default: out_cnt <= out_cnt;
      endcase
      if (core_req_i & ~core_gnt_o) stall_cnt <= sat_inc32(stall_cnt);
    end
  end

  // Stage p1: response register; data holds between valid beats
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= demux_r_valid_i;
      if (demux_r_valid_i) rdata_p1 <= demux_r_rdata_i;
    end
  end

  // A retiring response with nothing in flight means the demux broke protocol.
  assert property (@(posedge clk_i) disable iff (rst_i) vld_p1 |-> (out_cnt != '0));
  assert property (@(posedge clk_i) disable iff (rst_i) out_cnt <= MaxOut);

endmodule

// File: tb/tb_core_data_req_slice.sv
// Bench for core_data_req_slice: queue-based reference model with a
// per-cycle compare, directed scenarios and a randomized phase.
module tb_core_data_req_slice;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2;
  localparam int MAXO  = 4;
  localparam int OW    = $clog2(MAXO + 1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          core_req_i;
  logic [AW-1:0] core_add_i;
  logic          core_wen_i;
  logic [DW-1:0] core_wdata_i;
  logic [BW-1:0] core_be_i;
  logic          core_gnt_o;
  logic          core_r_valid_o;
  logic [DW-1:0] core_r_rdata_o;
  logic          demux_req_o;
  logic [AW-1:0] demux_add_o;
  logic          demux_wen_o;
  logic [DW-1:0] demux_wdata_o;
  logic [BW-1:0] demux_be_o;
  logic          demux_gnt_i;
  logic          demux_r_valid_i;
  logic [DW-1:0] demux_r_rdata_i;
  logic [OW-1:0] outstanding_o;
  logic [31:0]   stall_cnt_o;

  always #5 clk_i = ~clk_i;

  core_data_req_slice #(
    .AddrWidth(AW), .DataWidth(DW), .Depth(DEPTH), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_add_i(core_add_i), .core_wen_i(core_wen_i),
    .core_wdata_i(core_wdata_i), .core_be_i(core_be_i), .core_gnt_o(core_gnt_o),
    .core_r_valid_o(core_r_valid_o), .core_r_rdata_o(core_r_rdata_o),
    .demux_req_o(demux_req_o), .demux_add_o(demux_add_o), .demux_wen_o(demux_wen_o),
    .demux_wdata_o(demux_wdata_o), .demux_be_o(demux_be_o), .demux_gnt_i(demux_gnt_i),
    .demux_r_valid_i(demux_r_valid_i), .demux_r_rdata_i(demux_r_rdata_i),
    .outstanding_o(outstanding_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct packed {
    logic [AW-1:0] add;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } req_t;

  typedef struct {
    int            rdy;
    logic [DW-1:0] data;
  } rsp_t;

  // Reference model state
  req_t          mq[$];
  int            m_out;
  logic [31:0]   m_stall;
  logic          m_rvld;
  logic [DW-1:0] m_rdata;
  logic          m_gnt;
  int            m_pops;

  // Demux emulator state
  rsp_t          pend[$];
  int            hold;
  int            resp_pct;
  logic          fix_en;
  logic [DW-1:0] fix_data;
  logic          nxt_rv;
  logic [DW-1:0] nxt_rd;

  req_t dut_sent[$];
  req_t expq[$];
  logic obs_gnt, obs_rvld;
  int   cyc, n_pass, n_total;
  int   k, n, g, rv_k, gnt_k;
  logic [31:0] base;
  req_t c;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
  endfunction

  function automatic req_t cur_req();
    return {core_add_i, core_wen_i, core_wdata_i, core_be_i};
  endfunction

  task automatic set_payload(input logic wen);
    core_add_i   = $urandom;
    core_wen_i   = wen;
    core_wdata_i = $urandom;
    core_be_i    = BW'($urandom);
  endtask

  // One clock: compare at negedge, advance model and demux emulator, then
  // apply the emulator's response inputs just after the rising edge.
  task automatic tick();
    req_t cur, head;
    logic e_gnt, e_dreq, pop;
    rsp_t r;
    @(negedge clk_i);
    cur    = cur_req();
    e_gnt  = core_req_i && (mq.size() < DEPTH) && (m_out < MAXO);
    e_dreq = (mq.size() != 0);
    head   = e_dreq ? mq[0] : '0;
    chk("core_gnt", core_gnt_o, e_gnt);
    chk("demux_req", demux_req_o, e_dreq);
    chk("demux_payload", {demux_add_o, demux_wen_o, demux_wdata_o, demux_be_o}, head);
    chk("r_valid", core_r_valid_o, m_rvld);
    chk("r_rdata", core_r_rdata_o, m_rdata);
    chk("outstanding", outstanding_o, m_out);
    chk("stall_cnt", stall_cnt_o, m_stall);
    obs_gnt  = core_gnt_o;
    obs_rvld = core_r_valid_o;
    if (demux_req_o && demux_gnt_i)
      dut_sent.push_back({demux_add_o, demux_wen_o, demux_wdata_o, demux_be_o});
    pop = e_dreq && demux_gnt_i;
    if (rst_i) begin
      mq.delete();
      pend.delete();
      m_out   = 0;
      m_stall = '0;
      m_rvld  = 1'b0;
      m_rdata = '0;
      nxt_rv  = 1'b0;
      nxt_rd  = $urandom;
    end else begin
      if (pop) begin
        mq.delete(0);
        m_pops++;
        r.rdy  = cyc + 1;
        r.data = fix_en ? fix_data : DW'($urandom);
        pend.push_back(r);
      end
      if (e_gnt) mq.push_back(cur);
      m_out = m_out + (e_gnt ? 1 : 0) - (m_rvld ? 1 : 0);
      if (core_req_i && !e_gnt && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      m_rvld = demux_r_valid_i;
      if (demux_r_valid_i) m_rdata = demux_r_rdata_i;
      nxt_rv = 1'b0;
      nxt_rd = $urandom;
      if (hold == 0 && pend.size() > 0 && pend[0].rdy <= cyc + 1 &&
          $urandom_range(99) < resp_pct) begin
        nxt_rv = 1'b1;
        nxt_rd = pend[0].data;
        pend.delete(0);
      end
    end
    m_gnt = e_gnt && !rst_i;
    @(posedge clk_i);
    #1;
    cyc++;
    demux_r_valid_i = nxt_rv;
    demux_r_rdata_i = nxt_rd;
  endtask

  task automatic drain(input string name);
    int j = 0;
    core_req_i  = 1'b0;
    demux_gnt_i = 1'b1;
    hold        = 0;
    resp_pct    = 100;
    while ((mq.size() != 0 || pend.size() != 0 || m_out != 0 || m_rvld) && j < 60) begin
      tick();
      j++;
    end
    chk(name, (mq.size() == 0 && pend.size() == 0 && m_out == 0), 1);
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    mq.delete(); pend.delete(); dut_sent.delete();
    m_out = 0; m_stall = '0; m_rvld = 1'b0; m_rdata = '0; m_gnt = 1'b0; m_pops = 0;
    hold = 0; resp_pct = 100; fix_en = 1'b0; fix_data = '0;
    rst_i = 1'b1; core_req_i = 1'b0; core_add_i = '0; core_wen_i = 1'b0;
    core_wdata_i = '0; core_be_i = '0; demux_gnt_i = 1'b0;
    demux_r_valid_i = 1'b0; demux_r_rdata_i = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("reset_gnt", core_gnt_o, 0);
    chk("reset_demux_req", demux_req_o, 0);
    chk("reset_payload", {demux_add_o, demux_wen_o, demux_wdata_o, demux_be_o}, 0);
    chk("reset_rvalid", core_r_valid_o, 0);
    chk("reset_rdata", core_r_rdata_o, 0);
    chk("reset_outstanding", outstanding_o, 0);
    chk("reset_stall", stall_cnt_o, 0);
    tick();

    // Single read, demux answers the cycle after its gnt
    core_req_i = 1'b1; core_add_i = 32'h1000_0010; core_wen_i = 1'b1;
    core_wdata_i = '0; core_be_i = 4'hF; demux_gnt_i = 1'b1;
    fix_en = 1'b1; fix_data = 32'hDEAD_BEEF;
    #1 chk("single_gnt_c1", core_gnt_o, 1);
    tick();
    core_req_i = 1'b0;
    #1 chk("single_dreq_c2", demux_req_o, 1);
    chk("single_dadd_c2", demux_add_o, 32'h1000_0010);
    chk("single_dwen_c2", demux_wen_o, 1);
    tick();
    #1 chk("single_rvalid_c3", core_r_valid_o, 0);
    tick();
    #1 chk("single_rvalid_c4", core_r_valid_o, 1);
    chk("single_rdata_c4", core_r_rdata_o, 32'hDEAD_BEEF);
    tick();
    #1 chk("single_out_c5", outstanding_o, 0);
    fix_en = 1'b0;
    drain("single_drain");

    // Streaming: 16 back-to-back writes, demux always granting
    dut_sent.delete(); expq.delete();
    k = 0; n = 0; g = 0;
    demux_gnt_i = 1'b1; core_req_i = 1'b1; set_payload(1'b0);
    expq.push_back(cur_req());
    while (n < 16 && k < 64) begin
      #1;
      if (k >= 3) chk("stream_out_steady", outstanding_o, 3);
      tick();
      if (obs_gnt) g++;
      if (m_gnt) begin
        n++;
        if (n < 16) begin
          set_payload(1'b0);
          expq.push_back(cur_req());
        end else core_req_i = 1'b0;
      end
      k++;
    end
    chk("stream_cycles", k, 16);
    chk("stream_gnts", g, 16);
    drain("stream_drain");
    chk("stream_stall", stall_cnt_o, 0);
    chk("stream_count", dut_sent.size(), 16);
    for (int i = 0; i < 16 && i < dut_sent.size(); i++) chk("stream_order", dut_sent[i], expq[i]);

    // Demux blocked for 10 cycles
    dut_sent.delete(); expq.delete();
    base = m_stall; g = 0;
    demux_gnt_i = 1'b0; core_req_i = 1'b1; set_payload(1'b1);
    for (int i = 0; i < 10; i++) begin
      c = cur_req();
      tick();
      if (obs_gnt) g++;
      if (m_gnt) begin
        expq.push_back(c);
        set_payload(1'b1);
      end
    end
    chk("blocked_gnts", g, 2);
    chk("blocked_stall", stall_cnt_o - base, 8);
    demux_gnt_i = 1'b1;
    #1 chk("no_pop_through", core_gnt_o, 0);
    k = 0;
    do begin
      c = cur_req();
      tick();
      k++;
    end while (!m_gnt && k < 20);
    chk("blocked_regrant", m_gnt, 1);
    if (m_gnt) expq.push_back(c);
    core_req_i = 1'b0;
    drain("blocked_drain");
    chk("blocked_count", dut_sent.size(), 3);
    for (int i = 0; i < 3 && i < dut_sent.size(); i++) chk("blocked_order", dut_sent[i], expq[i]);

    // Outstanding cap: responses withheld
    hold = 1; g = 0;
    demux_gnt_i = 1'b1; core_req_i = 1'b1; set_payload(1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_gnt) g++;
      if (m_gnt) set_payload(1'b1);
    end
    chk("cap_gnts", g, 4);
    #1 chk("cap_out", outstanding_o, 4);
    chk("cap_gnt_low", core_gnt_o, 0);
    hold = 0; rv_k = -1; gnt_k = -1; k = 0;
    while (gnt_k < 0 && k < 20) begin
      tick();
      if (obs_rvld && rv_k < 0) rv_k = k;
      if (obs_gnt && gnt_k < 0) gnt_k = k;
      if (m_gnt) core_req_i = 1'b0;
      k++;
    end
    chk("cap_regnt_delay", gnt_k - rv_k, 1);
    drain("cap_drain");

    // Reset with 2 entries queued and 3 outstanding
    hold = 1; m_pops = 0; k = 0;
    core_req_i = 1'b1; set_payload(1'b1);
    while (!(mq.size() == 2 && m_out == 3) && k < 20) begin
      demux_gnt_i = (m_pops == 0);
      tick();
      if (m_gnt) set_payload(1'b1);
      k++;
    end
    #1 chk("prereset_out", outstanding_o, 3);
    chk("prereset_dreq", demux_req_o, 1);
    core_req_i = 1'b0; demux_gnt_i = 1'b0; rst_i = 1'b1;
    demux_r_valid_i = 1'b1; demux_r_rdata_i = 32'hCAFE_F00D;
    tick();
    rst_i = 1'b0; hold = 0;
    #1 chk("postrst_gnt", core_gnt_o, 0);
    chk("postrst_dreq", demux_req_o, 0);
    chk("postrst_payload", {demux_add_o, demux_wen_o, demux_wdata_o, demux_be_o}, 0);
    chk("postrst_rvalid", core_r_valid_o, 0);
    chk("postrst_rdata", core_r_rdata_o, 0);
    chk("postrst_out", outstanding_o, 0);
    chk("postrst_stall", stall_cnt_o, 0);
    core_req_i = 1'b1; set_payload(1'b0);
    c = cur_req();
    #1 chk("postrst_first_gnt", core_gnt_o, 1);
    tick();
    core_req_i = 1'b0;
    #1 chk("postrst_head", {demux_add_o, demux_wen_o, demux_wdata_o, demux_be_o}, c);
    drain("postrst_drain");

    // Randomized traffic with occasional resets
    resp_pct = 60; core_req_i = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!core_req_i || m_gnt) begin
        core_req_i = ($urandom_range(99) < 70);
        set_payload(1'($urandom));
      end
      demux_gnt_i = ($urandom_range(99) < 65);
      rst_i = ($urandom_range(999) == 0);
      if (rst_i) core_req_i = 1'b0;
      tick();
      rst_i = 1'b0;
    end
    drain("random_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
